// File: rtl/freeway_pkg.sv
// Shared constants, state type and strict rectangle test for the Freeway object engine.
package freeway_pkg;

   localparam int DEF_N_LANES     = 3;
   localparam int DEF_SCREEN_W    = 640;
   localparam int DEF_SCREEN_H    = 480;
   localparam int DEF_CAR_W       = 60;
   localparam int DEF_CAR_H       = 60;
   localparam int DEF_CHICK_W     = 30;
   localparam int DEF_CHICK_H     = 30;
   localparam int DEF_LANE_TOP    = 60;
   localparam int DEF_LANE_PITCH  = 120;
   localparam int DEF_STEP        = 60;
   localparam int DEF_START_ROW   = 435;
   localparam int DEF_START_COL   = 320;
   localparam int DEF_HOLD_FRAMES = 30;
   localparam int DEF_SCORE_W     = 8;

   localparam int POS_W = 11;
   typedef logic signed [POS_W-1:0] pos_t;

   typedef enum logic [0:0] {
      PLAY = 1'b0,
      HIT  = 1'b1
   } state_e;

   // True when (px, py) lies strictly inside the w x h rectangle anchored at (rx, ry).
   function automatic logic rect_hit(input int px, input int py, input int rx, input int ry,
                                     input int w, input int h);
      return (rx < px) && (px < rx + w) && (ry < py) && (py < ry + h);
   endfunction

endpackage

// File: rtl/freeway_if.sv
// Game-control and video signals between the timing/input side and the object engine.
interface freeway_if #(
   parameter int N_LANES = freeway_pkg::DEF_N_LANES,
   parameter int SCORE_W = freeway_pkg::DEF_SCORE_W
);
   logic                   frame_tick;
   logic                   btn_up;
   logic                   btn_down;
   logic [4*N_LANES-1:0]   lane_speed;
   logic [N_LANES-1:0]     lane_dir;
   logic [9:0]             row;
   logic [9:0]             column;
   logic                   pix_chicken;
   logic                   pix_car;
   logic [SCORE_W-1:0]     score;
   logic [SCORE_W-1:0]     hits;
   logic                   collision;

   modport master (
      output frame_tick, btn_up, btn_down, lane_speed, lane_dir, row, column,
      input  pix_chicken, pix_car, score, hits, collision
   );

   modport slave (
      input  frame_tick, btn_up, btn_down, lane_speed, lane_dir, row, column,
      output pix_chicken, pix_car, score, hits, collision
   );
endinterface

// File: rtl/freeway_lane.sv
// One car lane: horizontal position register that advances and wraps once per frame.
module freeway_lane
   import freeway_pkg::*;
#(
   parameter int SCREEN_W = DEF_SCREEN_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       dir,
   input  logic [3:0] speed,
   output pos_t       x
);

   localparam pos_t WRAP_X     = pos_t'(SCREEN_W);
   localparam pos_t LEFT_START = pos_t'(SCREEN_W - 40);

   pos_t x_q, x_d, moved;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      x_d   = x_q;
      moved = dir ? x_q - pos_t'(speed) : x_q + pos_t'(speed);
      if (tick && speed != 4'd0) begin
         if (dir) x_d = (moved <= pos_t'(0)) ? WRAP_X : moved;
         else     x_d = (moved >= WRAP_X)    ? pos_t'(0) : moved;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) x_q <= dir ? LEFT_START : pos_t'(0);
      else     x_q <= x_d;
   end

   assign x = x_q;

endmodule

// File: rtl/freeway_engine.sv
// Freeway game-object engine: car lanes, chicken FSM, collision, counters and sprite pixels.
module freeway_engine
   import freeway_pkg::*;
#(
   parameter int N_LANES     = DEF_N_LANES,
   parameter int SCREEN_W    = DEF_SCREEN_W,
   parameter int SCREEN_H    = DEF_SCREEN_H,
   parameter int CAR_W       = DEF_CAR_W,
   parameter int CAR_H       = DEF_CAR_H,
   parameter int CHICK_W     = DEF_CHICK_W,
   parameter int CHICK_H     = DEF_CHICK_H,
   parameter int LANE_TOP    = DEF_LANE_TOP,
   parameter int LANE_PITCH  = DEF_LANE_PITCH,
   parameter int STEP        = DEF_STEP,
   parameter int START_ROW   = DEF_START_ROW,
   parameter int START_COL   = DEF_START_COL,
   parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
   parameter int SCORE_W     = DEF_SCORE_W
) (
   input logic     clk,
   input logic     rst,
   freeway_if.slave bus
);

   // Blink reads hold bit 2, so the counter is never narrower than 3 bits.
   localparam int   HOLD_W  = (HOLD_FRAMES < 8) ? 3 : $clog2(HOLD_FRAMES + 1);
   localparam pos_t HOME_Y  = pos_t'(START_ROW);
   localparam pos_t CHICK_X = pos_t'(START_COL);
   localparam pos_t STEP_Y  = pos_t'(STEP);

   pos_t               lane_x [N_LANES];
   state_e             state_q, state_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   pos_t               cy_q, cy_d;
   logic [SCORE_W-1:0] score_q, score_d, hits_q, hits_d;
   logic               btn_up_q, btn_up_d, btn_down_q, btn_down_d;
   logic               up_pend_q, up_pend_d, down_pend_q, down_pend_d;
   logic               collision_q, collision_d;
   logic               pix_chicken_q, pix_chicken_d, pix_car_q, pix_car_d;
   logic               up_edge, down_edge, hit_any, visible;

   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      freeway_lane #(.SCREEN_W(SCREEN_W)) u_lane (
         .clk   (clk),
         .rst   (rst),
         .tick  (bus.frame_tick),
         .dir   (bus.lane_dir[i]),
         .speed (bus.lane_speed[4*i +: 4]),
         .x     (lane_x[i])
      );
   end

   assign up_edge   = bus.btn_up   & ~btn_up_q;
   assign down_edge = bus.btn_down & ~btn_down_q;

   // Chicken/car overlap is the chicken corner strictly inside the car grown by the chicken size.
   always_comb begin
      hit_any   = 1'b0;
      pix_car_d = 1'b0;
      visible   = int'(bus.row) < SCREEN_H;
      for (int i = 0; i < N_LANES; i++) begin
         if (rect_hit(int'(CHICK_X), int'(cy_q),
                      int'(lane_x[i]) - CHICK_W, LANE_TOP + i * LANE_PITCH - CHICK_H,
                      CAR_W + CHICK_W, CAR_H + CHICK_H))
            hit_any = 1'b1;
         if (rect_hit(int'(bus.column), int'(bus.row),
                      int'(lane_x[i]), LANE_TOP + i * LANE_PITCH, CAR_W, CAR_H))
            pix_car_d = visible;
      end
      pix_chicken_d = visible
                   && rect_hit(int'(bus.column), int'(bus.row), int'(CHICK_X), int'(cy_q),
                               CHICK_W, CHICK_H)
                   && !(state_q == HIT && hold_q[2]);
   end

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      cy_d        = cy_q;
      score_d     = score_q;
      hits_d      = hits_q;
      collision_d = 1'b0;
      btn_up_d    = bus.btn_up;
      btn_down_d  = bus.btn_down;
      up_pend_d   = up_pend_q   | up_edge;
      down_pend_d = down_pend_q | down_edge;

      unique case (state_q)
         PLAY: begin
            if (bus.frame_tick) begin
               // Pending moves are consumed by this tick; an edge in the same cycle waits for the next.
               up_pend_d   = up_edge;
               down_pend_d = down_edge;
               if (hit_any) begin
                  hits_d      = (hits_q == '1) ? hits_q : hits_q + SCORE_W'(1);
                  collision_d = 1'b1;
                  hold_d      = HOLD_W'(HOLD_FRAMES);
                  state_d     = HIT;
                  up_pend_d   = 1'b0;
                  down_pend_d = 1'b0;
               end else if (up_pend_q && !down_pend_q) begin
                  if (cy_q <= STEP_Y) begin
                     score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                     cy_d    = HOME_Y;
                  end else begin
                     cy_d = cy_q - STEP_Y;
                  end
               end else if (down_pend_q && !up_pend_q) begin
                  cy_d = (cy_q + STEP_Y > HOME_Y) ? HOME_Y : cy_q + STEP_Y;
               end
            end
         end
         HIT: begin
            up_pend_d   = 1'b0;
            down_pend_d = 1'b0;
            if (bus.frame_tick) begin
               hold_d = hold_q - HOLD_W'(1);
               if (hold_q == HOLD_W'(1)) begin
                  cy_d    = HOME_Y;
                  state_d = PLAY;
               end
            end
         end
         default: state_d = PLAY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= PLAY;
         hold_q        <= '0;
         cy_q          <= HOME_Y;
         score_q       <= '0;
         hits_q        <= '0;
         btn_up_q      <= 1'b1;
         btn_down_q    <= 1'b1;
         up_pend_q     <= 1'b0;
         down_pend_q   <= 1'b0;
         collision_q   <= 1'b0;
         pix_chicken_q <= 1'b0;
         pix_car_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         cy_q          <= cy_d;
         score_q       <= score_d;
         hits_q        <= hits_d;
         btn_up_q      <= btn_up_d;
         btn_down_q    <= btn_down_d;
         up_pend_q     <= up_pend_d;
         down_pend_q   <= down_pend_d;
         collision_q   <= collision_d;
         pix_chicken_q <= pix_chicken_d;
         pix_car_q     <= pix_car_d;
      end
   end

   assign bus.score       = score_q;
   assign bus.hits        = hits_q;
   assign bus.collision   = collision_q;
   assign bus.pix_chicken = pix_chicken_q;
   assign bus.pix_car     = pix_car_q;

endmodule

// File: tb/tb_freeway_engine.sv
// Directed bench for freeway_engine: reset state, lane wrap, crossing, collision/hold, edges, pixels.
module tb_freeway_engine;
   import freeway_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   freeway_if #(.N_LANES(3), .SCORE_W(8)) bus ();

   freeway_engine #(.N_LANES(3), .SCORE_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   task automatic apply_reset(input logic [2:0] dir, input logic [11:0] speed);
      @(negedge clk);
      rst            = 1'b1;
      bus.frame_tick = 1'b0;
      bus.lane_dir   = dir;
      bus.lane_speed = speed;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
   endtask

   task automatic press(input logic up, input logic down);
      @(negedge clk);
      bus.btn_up   = up;
      bus.btn_down = down;
      @(negedge clk);
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
   endtask

   task automatic pixel(input int r, input int c);
      @(negedge clk);
      bus.row    = 10'(r);
      bus.column = 10'(c);
      @(negedge clk);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int exp_cy [7] = '{375, 315, 255, 195, 135, 75, 15};

      rst            = 1'b1;
      bus.frame_tick = 1'b0;
      bus.btn_up     = 1'b1;
      bus.btn_down   = 1'b0;
      bus.lane_speed = '0;
      bus.lane_dir   = 3'b101;
      bus.row        = '0;
      bus.column     = '0;

      // Reset state, with btn_up held through reset
      apply_reset(3'b101, 12'h000);
      check("rst_score",     32'(bus.score), 0);
      check("rst_hits",      32'(bus.hits), 0);
      check("rst_collision", 32'(bus.collision), 0);
      check("rst_pix_chick", 32'(bus.pix_chicken), 0);
      check("rst_pix_car",   32'(bus.pix_car), 0);
      check("rst_cy",        32'(dut.cy_q), 435);
      check("rst_state",     32'(dut.state_q), 32'(PLAY));
      check("rst_lane0_x",   32'(dut.lane_x[0]), 600);
      check("rst_lane1_x",   32'(dut.lane_x[1]), 0);
      check("rst_lane2_x",   32'(dut.lane_x[2]), 600);

      tick();
      check("held_btn_no_move", 32'(dut.cy_q), 435);
      bus.btn_up = 1'b0;

      press(1'b1, 1'b1);
      tick();
      check("both_edges_discard", 32'(dut.cy_q), 435);
      tick();
      check("both_flags_cleared", 32'(dut.cy_q), 435);
      press(1'b0, 1'b1);
      tick();
      check("down_at_home", 32'(dut.cy_q), 435);

      // Pixels: chicken at home (320,435), lane 0 car at (600,60)
      pixel(436, 321);
      check("pix_chick_inside", 32'(bus.pix_chicken), 1);
      pixel(435, 321);
      check("pix_chick_edge_row", 32'(bus.pix_chicken), 0);
      pixel(61, 601);
      check("pix_car_inside", 32'(bus.pix_car), 1);
      pixel(60, 601);
      check("pix_car_edge_row", 32'(bus.pix_car), 0);

      // Crossing: 8 spaced up presses
      apply_reset(3'b101, 12'h000);
      for (int k = 0; k < 7; k++) begin
         press(1'b1, 1'b0);
         tick();
         check($sformatf("cross_cy_%0d", k + 1), 32'(dut.cy_q), 32'(exp_cy[k]));
      end
      press(1'b1, 1'b0);
      tick();
      check("cross_score", 32'(bus.score), 1);
      check("cross_cy_home", 32'(dut.cy_q), 435);
      check("cross_hits", 32'(bus.hits), 0);

      // Leftward wrap: lane 0 speed 2 from 600
      apply_reset(3'b101, 12'h002);
      tick();
      check("lane0_first", 32'(dut.lane_x[0]), 598);
      repeat (298) tick();
      check("lane0_at_2", 32'(dut.lane_x[0]), 2);
      tick();
      check("lane0_wrap", 32'(dut.lane_x[0]), 640);
      check("lane1_frozen", 32'(dut.lane_x[1]), 0);

      // Rightward wrap: lane 1 speed 3 from 0
      apply_reset(3'b101, 12'h030);
      repeat (212) tick();
      check("lane1_at_636", 32'(dut.lane_x[1]), 636);
      tick();
      check("lane1_639", 32'(dut.lane_x[1]), 639);
      tick();
      check("lane1_wrap", 32'(dut.lane_x[1]), 0);

      // Collision: chicken to 315, lane 2 leftward speed 1
      apply_reset(3'b101, 12'h000);
      press(1'b1, 1'b0); tick();
      press(1'b1, 1'b0); tick();
      press(1'b0, 1'b1); tick();
      check("down_mid", 32'(dut.cy_q), 375);
      press(1'b1, 1'b0); tick();
      check("coll_setup_cy", 32'(dut.cy_q), 315);
      bus.lane_speed = 12'h100;
      repeat (251) tick();
      check("coll_lane2_349", 32'(dut.lane_x[2]), 349);
      check("coll_none_yet", 32'(bus.hits), 0);
      bus.row    = 10'd316;
      bus.column = 10'd321;
      tick();
      check("coll_pulse", 32'(bus.collision), 1);
      check("coll_hits", 32'(bus.hits), 1);
      check("coll_state_hit", 32'(dut.state_q), 32'(HIT));
      check("coll_lane2_moves", 32'(dut.lane_x[2]), 348);
      @(negedge clk);
      check("coll_pulse_end", 32'(bus.collision), 0);
      check("blink_off", 32'(bus.pix_chicken), 0);

      press(1'b1, 1'b0); tick();
      press(1'b1, 1'b0); tick();
      tick();
      @(negedge clk);
      check("blink_on", 32'(bus.pix_chicken), 1);
      check("hit_cy_frozen", 32'(dut.cy_q), 315);
      repeat (26) tick();
      check("hit_still_hit", 32'(dut.state_q), 32'(HIT));
      check("hit_cy_29", 32'(dut.cy_q), 315);
      press(1'b1, 1'b0);
      tick();
      check("hit_done_cy", 32'(dut.cy_q), 435);
      check("hit_done_state", 32'(dut.state_q), 32'(PLAY));
      tick();
      check("hit_press_ignored", 32'(dut.cy_q), 435);
      check("hit_hits_final", 32'(bus.hits), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
